// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: one outstanding valid/ready read to instruction memory,
// holds the fetched word for the core, and reports misalignment, bus-error and timeout faults.
module ysyx_23060020_ifu #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  output logic             imem_rsp_ready,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT, DRAIN} state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_BUS  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] timer;

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  assign imem_req_valid = (state == REQ);
  assign imem_rsp_ready = (state == WAIT) || (state == DRAIN);
  assign inst_valid     = (state == DONE);
  assign fault          = (state == FAULT);
  assign imem_req_addr  = addr_q;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it is evaluated only at the clock edge.
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      timer       <= '0;
      inst        <= '0;
      inst_pc     <= '0;
      fault_cause <= CAUSE_NONE;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && fetch_en) begin
            addr_q <= pc;
            if (pc[1:0] != 2'b00) begin
              state       <= FAULT;
              fault_cause <= CAUSE_MIS;
              inst_pc     <= pc;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (flush) begin
            // An accepted request still owes a response, which must be swallowed.
            state <= imem_req_ready ? DRAIN : IDLE;
            timer <= '0;
          end else if (imem_req_ready) begin
            state <= WAIT;
            timer <= '0;
          end
        end

        WAIT: begin
          if (flush) begin
            state <= imem_rsp_valid ? IDLE : DRAIN;
            timer <= '0;
          end else if (imem_rsp_valid) begin
            inst_pc <= addr_q;
            if (imem_rsp_err) begin
              state       <= FAULT;
              fault_cause <= CAUSE_BUS;
            end else begin
              state <= DONE;
              inst  <= imem_rsp_data;
            end
          end else if (TMO_EN && timer == TMO_LAST) begin
            state       <= FAULT;
            fault_cause <= CAUSE_TMO;
            inst_pc     <= addr_q;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (inst_ready) begin
            state     <= IDLE;
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end

        FAULT: begin
          if (flush) begin
            state       <= IDLE;
            fault_cause <= CAUSE_NONE;
          end
        end

        DRAIN: begin
          // Flushes are ignored here; a lost response must not wedge the unit.
          if (imem_rsp_valid) begin
            state <= IDLE;
          end else if (TMO_EN && timer == TMO_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// Directed testbench for ysyx_23060020_ifu (TIMEOUT=8, CNT_W=4); memory and core sides
// are driven step by step with hand-computed expectations.
module tb_ysyx_23060020_ifu;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_en;
  logic [31:0]      pc;
  logic             flush;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic             imem_rsp_ready;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_err;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [CNT_W-1:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_23060020_ifu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .pc             (pc),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_rsp_ready"}, 32'(imem_rsp_ready), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_cause"}, 32'(fault_cause), 32'd0);
    check({tag, "_cnt"}, 32'(fetch_cnt), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, 32'd0);
  endtask

  // Zero-wait fetch from IDLE up to DONE; the word is left unconsumed.
  task automatic fetch_to_done(input string tag, input logic [31:0] a, input logic [31:0] d);
    pc = a; fetch_en = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, a);
    tick();
    imem_req_ready = 1'b0;
    check({tag, "_wait_rsp_ready"}, 32'(imem_rsp_ready), 32'd1);
    imem_rsp_valid = 1'b1; imem_rsp_data = d;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, inst, d);
    check({tag, "_inst_pc"}, inst_pc, a);
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  // Issue a request, get it accepted, and stop with the unit in WAIT.
  task automatic fetch_to_wait(input logic [31:0] a);
    pc = a; fetch_en = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    imem_req_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; pc = 32'h0; flush = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check_reset_values("reset");

    // Zero-wait fetch and consume.
    fetch_to_done("zw", 32'h8000_0000, 32'h0010_0073);
    consume();
    check("zw_after_valid", 32'(inst_valid), 32'd0);
    check("zw_cnt", 32'(fetch_cnt), 32'd1);

    // Backpressure on request, response and consumer sides.
    pc = 32'h8000_0010; fetch_en = 1'b1; imem_req_ready = 1'b0;
    tick();
    fetch_en = 1'b0; pc = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h8000_0010);
      tick();
    end
    check("bp_req_still", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("bp_req_dropped", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp_wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      check("bp_wait_no_inst", 32'(inst_valid), 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(inst_valid), 32'd1);
      check("bp_hold_inst", inst, 32'hCAFE_F00D);
      check("bp_hold_pc", inst_pc, 32'h8000_0010);
      tick();
    end
    consume();
    check("bp_cnt", 32'(fetch_cnt), 32'd2);
    check("bp_idle_valid", 32'(inst_valid), 32'd0);

    // Misaligned PC.
    pc = 32'h8000_0002; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("mis_req_valid", 32'(imem_req_valid), 32'd0);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_cause", 32'(fault_cause), 32'd1);
    check("mis_inst_pc", inst_pc, 32'h8000_0002);
    tick();
    check("mis_sticky", 32'(fault), 32'd1);
    check("mis_no_req", 32'(imem_req_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("mis_clr_fault", 32'(fault), 32'd0);
    check("mis_clr_cause", 32'(fault_cause), 32'd0);
    check("mis_clr_cnt", 32'(fetch_cnt), 32'd2);

    // Bus error response.
    fetch_to_wait(32'h8000_0020);
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h5555_5555;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = 32'h0;
    check("bus_fault", 32'(fault), 32'd1);
    check("bus_cause", 32'(fault_cause), 32'd2);
    check("bus_no_inst", 32'(inst_valid), 32'd0);
    check("bus_inst_pc", inst_pc, 32'h8000_0020);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("bus_clr_fault", 32'(fault), 32'd0);
    check("bus_clr_cause", 32'(fault_cause), 32'd0);

    // Timeout: seven silent WAIT cycles stay in WAIT, the eighth faults.
    fetch_to_wait(32'h8000_0030);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tmo_not_yet", 32'(fault), 32'd0);
    end
    tick();
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_cause", 32'(fault_cause), 32'd3);
    check("tmo_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("tmo_clr_fault", 32'(fault), 32'd0);
    check("tmo_clr_cause", 32'(fault_cause), 32'd0);

    // Flush in WAIT; the late response is swallowed.
    fetch_to_wait(32'h8000_0040);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fw_drain_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    check("fw_drain_no_inst", 32'(inst_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check("fw_idle_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    check("fw_idle_no_inst", 32'(inst_valid), 32'd0);
    fetch_to_done("fw_next", 32'h8000_0004, 32'h0000_0513);
    consume();
    check("fw_cnt", 32'(fetch_cnt), 32'd3);

    // Flush on the cycle the request is accepted.
    pc = 32'h8000_0050; fetch_en = 1'b1; imem_req_ready = 1'b0;
    tick();
    fetch_en = 1'b0; imem_req_ready = 1'b1; flush = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b0;
    check("fr_drain_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    check("fr_drain_req_valid", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check("fr_idle_no_inst", 32'(inst_valid), 32'd0);
    check("fr_idle_rsp_ready", 32'(imem_rsp_ready), 32'd0);

    // Flush in DONE while inst_ready is high: no count.
    fetch_to_done("fd", 32'h8000_0060, 32'h0020_0093);
    inst_ready = 1'b1; flush = 1'b1;
    tick();
    inst_ready = 1'b0; flush = 1'b0;
    check("fd_valid", 32'(inst_valid), 32'd0);
    check("fd_cnt", 32'(fetch_cnt), 32'd3);

    // Reset while in WAIT.
    fetch_to_wait(32'h8000_0070);
    check("rw_in_wait", 32'(imem_rsp_ready), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_values("rst_wait");

    // Sixteen fetches wrap a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      fetch_to_done("wrap", 32'h8000_0100 + 32'(i) * 4, 32'hA000_0000 + 32'(i));
      consume();
      if (i == 14) check("wrap_cnt15", 32'(fetch_cnt), 32'd15);
    end
    check("wrap_cnt0", 32'(fetch_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
